// File: rtl/mips32_mem_pkg.sv
// Shared memory-path definitions: bridge state encoding and RAM word geometry.
package mips32_mem_pkg;
   localparam int LANES = 4;
   localparam int WORD  = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RDWAIT = 2'd1,
      ACK    = 2'd2,
      HOLD   = 2'd3
   } bridgeState_t;
endpackage

// File: rtl/mips32_ram_bridge.sv
// Bridges the core's held-request data port to the single-port block RAM.
// Latency: write/error ready at +1, read ready at +2; a HOLD cycle follows every ready pulse.
module mips32_ram_bridge
   import mips32_mem_pkg::*;
#(
   parameter int          AWIDTH = 12,
   parameter logic [29:0] BASE   = 30'h0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_read,
   input  logic [LANES-1:0]  cpu_write,
   input  logic [29:0]       cpu_addr,
   input  logic [WORD-1:0]   cpu_wdata,
   output logic [WORD-1:0]   cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_error,
   output logic [AWIDTH-1:0] ram_readAddr,
   input  logic [WORD-1:0]   ram_readData,
   output logic [AWIDTH-1:0] ram_writeAddr,
   output logic [WORD-1:0]   ram_writeData,
   output logic [LANES-1:0]  ram_writeLane,
   output logic              ram_writeEnable
);

   bridgeState_t state;

   logic hit;
   logic anyWrite;
   logic validWrite;
   logic validRead;
   logic request;

   assign hit        = (cpu_addr[29:AWIDTH] == BASE[29:AWIDTH]);
   assign anyWrite   = |cpu_write;
   assign validWrite = anyWrite && !cpu_read && hit;
   assign validRead  = cpu_read && !anyWrite && hit;
   assign request    = cpu_read || anyWrite;

   // The RAM registers its read address every cycle, so the address just streams through.
   assign ram_readAddr  = cpu_addr[AWIDTH-1:0];
   assign ram_writeAddr = cpu_addr[AWIDTH-1:0];
   assign ram_writeData = cpu_wdata;

   // Write strobes exist only in the IDLE cycle, so a held request cannot write twice.
   always_comb begin
      ram_writeLane = '0;
      if (!reset && state == IDLE && validWrite)
         ram_writeLane = cpu_write;
      ram_writeEnable = |ram_writeLane;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cpu_ready <= 1'b0;
         cpu_error <= 1'b0;
         cpu_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (validWrite) begin
                  state     <= ACK;
                  cpu_ready <= 1'b1;
                  cpu_error <= 1'b0;
               end else if (validRead) begin
                  state <= RDWAIT;
               end else if (request) begin
                  state     <= ACK;
                  cpu_ready <= 1'b1;
                  cpu_error <= 1'b1;
                  if (cpu_read)
                     cpu_rdata <= '0;
               end
            end
            RDWAIT: begin
               cpu_rdata <= ram_readData;
               cpu_ready <= 1'b1;
               cpu_error <= 1'b0;
               state     <= ACK;
            end
            ACK: begin
               cpu_ready <= 1'b0;
               cpu_error <= 1'b0;
               state     <= HOLD;
            end
            HOLD: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips32_ram_bridge.sv
// Bench for mips32_ram_bridge: directed vector table, hand sequences and random accesses vs. a word-array model.
module tb_mips32_ram_bridge;

   logic        clock = 1'b0;
   logic        reset;
   logic        cpu_read;
   logic [3:0]  cpu_write;
   logic [29:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        cpu_error;
   logic [11:0] ram_readAddr;
   logic [31:0] ram_readData;
   logic [11:0] ram_writeAddr;
   logic [31:0] ram_writeData;
   logic [3:0]  ram_writeLane;
   logic        ram_writeEnable;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mips32_ram_bridge #(.AWIDTH(12), .BASE(30'h0)) dut (
      .clock(clock), .reset(reset),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_error(cpu_error),
      .ram_readAddr(ram_readAddr), .ram_readData(ram_readData),
      .ram_writeAddr(ram_writeAddr), .ram_writeData(ram_writeData),
      .ram_writeLane(ram_writeLane), .ram_writeEnable(ram_writeEnable)
   );

   // Block RAM with registered read address and byte-lane writes.
   logic [31:0] ramMem [0:4095];
   logic [11:0] ramAddrQ;
   always @(posedge clock) begin
      ramAddrQ <= ram_readAddr;
      if (ram_writeEnable)
         for (int i = 0; i < 4; i++)
            if (ram_writeLane[i]) ramMem[ram_writeAddr][8*i +: 8] <= ram_writeData[8*i +: 8];
   end
   assign ram_readData = ramMem[ramAddrQ];

   // Reference model: one 32-bit word per window index.
   logic [31:0] mdl [int];

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] ln);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++) if (ln[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic modelUpdate(input logic rd, input logic [3:0] wr, input logic [29:0] addr, input logic [31:0] wd);
      int idx = int'(addr[11:0]);
      if (!rd && wr != 0 && addr[29:12] == 0)
         mdl[idx] = merge(mdl.exists(idx) ? mdl[idx] : 32'h0, wd, wr);
   endtask

   // Caller must be just after an edge with the bridge in IDLE; returns in IDLE.
   task automatic doAccess(input logic rd, input logic [3:0] wr, input logic [29:0] addr, input logic [31:0] wd,
                           input logic expErr, input int expLat, input logic chkData, input logic [31:0] expData,
                           input string name);
      int   lat = -1;
      logic sawStrobe = 1'b0;
      logic [3:0] lanes = 4'h0;
      logic expStrobe = !expErr && wr != 0;
      cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wd;
      for (int n = 0; n < 8; n++) begin
         @(negedge clock);
         if (n == 0) begin
            chk({name, " readAddr"}, {20'h0, ram_readAddr}, {20'h0, addr[11:0]});
            chk({name, " writeData"}, ram_writeData, wd);
         end
         if (ram_writeEnable) begin sawStrobe = 1'b1; lanes = ram_writeLane; end
         if (cpu_ready) begin lat = n; break; end
      end
      chk({name, " latency"}, lat, expLat);
      chk({name, " error"}, {31'h0, cpu_error}, {31'h0, expErr});
      if (chkData) chk({name, " rdata"}, cpu_rdata, expData);
      chk({name, " strobe"}, {27'h0, sawStrobe, lanes}, {27'h0, expStrobe, expStrobe ? wr : 4'h0});
      modelUpdate(rd, wr, addr, wd);
      @(posedge clock); #1;
      cpu_read = 1'b0; cpu_write = 4'h0;
      @(negedge clock);
      chk({name, " hold"}, {31'h0, cpu_ready}, 32'h0);
      @(posedge clock); #1;
   endtask

   typedef struct {
      logic        rd;
      logic [3:0]  wr;
      logic [29:0] addr;
      logic [31:0] wd;
      logic        expErr;
      int          expLat;
      logic        chkData;
      logic [31:0] expData;
   } vec_t;

   vec_t vecs [12];

   initial begin
      #500000;
      $display("FAIL global timeout");
      $fatal(1);
   end

   initial begin
      int lat, pulses;
      vecs[0]  = '{1'b0, 4'hF, 30'h10,       32'hDEADBEEF, 1'b0, 1, 1'b0, 32'h0};
      vecs[1]  = '{1'b1, 4'h0, 30'h10,       32'h0,        1'b0, 2, 1'b1, 32'hDEADBEEF};
      vecs[2]  = '{1'b0, 4'hF, 30'h20,       32'h11223344, 1'b0, 1, 1'b0, 32'h0};
      vecs[3]  = '{1'b0, 4'h2, 30'h20,       32'h0000AB00, 1'b0, 1, 1'b0, 32'h0};
      vecs[4]  = '{1'b1, 4'h0, 30'h20,       32'h0,        1'b0, 2, 1'b1, 32'h1122AB44};
      vecs[5]  = '{1'b1, 4'h0, 30'h1000,     32'h0,        1'b1, 1, 1'b1, 32'h0};
      vecs[6]  = '{1'b1, 4'h1, 30'h10,       32'hFFFFFFFF, 1'b1, 1, 1'b1, 32'h0};
      vecs[7]  = '{1'b1, 4'h0, 30'h10,       32'h0,        1'b0, 2, 1'b1, 32'hDEADBEEF};
      vecs[8]  = '{1'b0, 4'hF, 30'h3FFFFFFF, 32'h55555555, 1'b1, 1, 1'b0, 32'h0};
      vecs[9]  = '{1'b0, 4'hF, 30'hFFF,      32'hCAFEF00D, 1'b0, 1, 1'b0, 32'h0};
      vecs[10] = '{1'b1, 4'h0, 30'h1FFF,     32'h0,        1'b1, 1, 1'b1, 32'h0};
      vecs[11] = '{1'b1, 4'h0, 30'hFFF,      32'h0,        1'b0, 2, 1'b1, 32'hCAFEF00D};

      reset = 1'b1; cpu_read = 1'b0; cpu_write = 4'h0; cpu_addr = '0; cpu_wdata = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset ready", {31'h0, cpu_ready}, 32'h0);
      chk("reset error", {31'h0, cpu_error}, 32'h0);
      chk("reset rdata", cpu_rdata, 32'h0);
      chk("reset strobe", {27'h0, ram_writeEnable, ram_writeLane}, 32'h0);
      @(posedge clock); #1;
      reset = 1'b0;

      foreach (vecs[i])
         doAccess(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].expErr,
                  vecs[i].expLat, vecs[i].chkData, vecs[i].expData, $sformatf("vec%0d", i));

      // Read held across its own completion: one pulse, HOLD gap, then re-accepted in IDLE.
      cpu_read = 1'b1; cpu_addr = 30'h10;
      pulses = 0; lat = -1;
      for (int n = 0; n < 5; n++) begin
         @(negedge clock);
         if (cpu_ready) begin pulses++; lat = n; end
         if (n == 3) chk("held hold-gap", {31'h0, cpu_ready}, 32'h0);
      end
      chk("held pulses", pulses, 1);
      chk("held latency", lat, 2);
      @(posedge clock); #1;
      cpu_read = 1'b0;
      lat = -1;
      for (int n = 5; n < 12; n++) begin
         @(negedge clock);
         if (cpu_ready) begin lat = n; break; end
      end
      chk("dropped-read latency", lat, 6);
      chk("dropped-read rdata", cpu_rdata, 32'hDEADBEEF);
      @(posedge clock); @(posedge clock); #1;

      // Reset while the read is in RDWAIT discards the pending ready.
      cpu_read = 1'b1; cpu_addr = 30'h20;
      @(posedge clock); #1;
      reset = 1'b1; cpu_read = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("midreset ready", {31'h0, cpu_ready}, 32'h0);
      chk("midreset error", {31'h0, cpu_error}, 32'h0);
      chk("midreset rdata", cpu_rdata, 32'h0);
      @(posedge clock); #1;
      doAccess(1'b1, 4'h0, 30'h20, 32'h0, 1'b0, 2, 1'b1, 32'h1122AB44, "post-reset read");

      // Seed the random address pool so every read has a known expected word.
      for (int i = 0; i < 16; i++)
         doAccess(1'b0, 4'hF, 30'h100 + 30'(i), $urandom, 1'b0, 1, 1'b0, 32'h0, "seed");

      for (int k = 0; k < 150; k++) begin
         int          kind = $urandom_range(0, 9);
         int          idx  = 32'h100 + $urandom_range(0, 15);
         logic        rd;
         logic [3:0]  wr;
         logic [29:0] addr = 30'(idx);
         logic [31:0] wd = $urandom;
         logic        err;
         if (kind <= 3) begin
            rd = 1'b0; wr = 4'($urandom_range(1, 15)); err = 1'b0;
         end else if (kind <= 7) begin
            rd = 1'b1; wr = 4'h0; err = 1'b0;
         end else if (kind == 8) begin
            rd = $urandom_range(0, 1) == 1;
            wr = rd ? 4'h0 : 4'($urandom_range(1, 15));
            addr = {18'($urandom_range(1, 262143)), 12'(idx)};
            err = 1'b1;
         end else begin
            rd = 1'b1; wr = 4'($urandom_range(1, 15)); err = 1'b1;
         end
         doAccess(rd, wr, addr, wd, err, (rd && !err) ? 2 : 1, rd,
                  (rd && !err) ? mdl[idx] : 32'h0, $sformatf("rand%0d", k));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
